// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the control sequencer: FSM states, opcodes,
// ALU select codes and the control-word structure.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH1 = 4'd0,
    ST_FETCH2 = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXA    = 4'd3,
    ST_EXM_RD = 4'd4,
    ST_EXM_WR = 4'd5,
    ST_EXALU  = 4'd6,
    ST_JUMP   = 4'd7,
    ST_HALT   = 4'd8,
    ST_FAULT  = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_NONE = 3'b000;

  localparam int WAIT_CNT_W = 8;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ir_load;
    logic ir_out;
    logic mem_rd;
    logic mem_wr;
    logic rega_load;
    logic rega_out;
    logic alu_out;
    logic halted;
    logic fault;
  } ctrl_t;

  function automatic logic [2:0] alu_sel(input logic [3:0] opcode);
    logic [2:0] sel;
    case (opcode)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      default: sel = ALU_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic is_wait_state(input state_t s);
    logic w;
    case (s)
      ST_FETCH2, ST_EXM_RD, ST_EXM_WR: w = 1'b1;
      default:                         w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus/handshake bundle between the control sequencer (master) and the
// datapath/memory side (slave).
interface control_sequencer_if;

  logic [15:0] bus_in;
  logic        mem_ready;
  logic        zero;

  logic        pc_out;
  logic        pc_inc;
  logic        pc_load;
  logic        mar_load;
  logic        ir_load;
  logic        ir_out;
  logic        mem_rd;
  logic        mem_wr;
  logic        rega_load;
  logic        rega_out;
  logic        alu_out;
  logic        halted;
  logic        fault;
  logic [2:0]  alu_op;
  logic [15:0] ir_operand;
  logic [3:0]  state;

  modport master (
    input  bus_in, mem_ready, zero,
    output pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out,
           mem_rd, mem_wr, rega_load, rega_out, alu_out, halted, fault,
           alu_op, ir_operand, state
  );

  modport slave (
    output bus_in, mem_ready, zero,
    input  pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out,
           mem_rd, mem_wr, rega_load, rega_out, alu_out, halted, fault,
           alu_op, ir_operand, state
  );

endinterface

// File: rtl/wait_timer.sv
// Memory wait-state counter; expired flags the last cycle a handshake may
// still complete before the sequencer gives up.
module wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic r,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  // Count value seen in the WAIT_MAX-th wait cycle (counting starts at zero).
  localparam logic [WAIT_CNT_W-1:0] LAST_COUNT = WAIT_CNT_W'(WAIT_MAX - 1);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  // Next-count selection: clear on wait-state entry, step on each unready cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry compare.
  always_comb begin
    if (count_q == LAST_COUNT) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer for a small accumulator CPU: fetch,
// decode and execute states with memory handshakes bounded by a wait timer.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input logic               clk,
  input logic               r,
  control_sequencer_if.master cs
);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] ir_q;
  logic [15:0] ir_d;
  logic [3:0]  opcode_s;

  ctrl_t       ctrl_s;
  ctrl_t       ctrl_out_s;
  logic [2:0]  alu_s;
  logic [2:0]  alu_out_s;

  logic        clear_s;
  logic        tick_s;
  logic        expired_s;

  assign opcode_s = ir_q[15:12];

  wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .r      (r),
    .clear  (clear_s),
    .tick   (tick_s),
    .expired(expired_s)
  );

  // State and instruction registers.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= ST_FETCH1;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and control decode; mem_ready only matters inside wait states.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ctrl_s  = '0;
    alu_s   = ALU_NONE;
    tick_s  = 1'b0;
    case (state_q)
      ST_FETCH1: begin
        ctrl_s.pc_out   = 1'b1;
        ctrl_s.mar_load = 1'b1;
        state_d         = ST_FETCH2;
      end
      ST_FETCH2: begin
        ctrl_s.mem_rd = 1'b1;
        if (cs.mem_ready) begin
          ctrl_s.ir_load = 1'b1;
          ctrl_s.pc_inc  = 1'b1;
          ir_d           = cs.bus_in;
          state_d        = ST_DECODE;
        end else if (expired_s) begin
          state_d = ST_FAULT;
        end else begin
          tick_s = 1'b1;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_NOP:                        state_d = ST_FETCH1;
          OP_LDA, OP_STA:                state_d = ST_EXA;
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_EXALU;
          OP_JMP:                        state_d = ST_JUMP;
          OP_JZ: begin
            if (cs.zero) begin
              state_d = ST_JUMP;
            end else begin
              state_d = ST_FETCH1;
            end
          end
          OP_HLT:                        state_d = ST_HALT;
          default:                       state_d = ST_FAULT;
        endcase
      end
      ST_EXA: begin
        ctrl_s.ir_out   = 1'b1;
        ctrl_s.mar_load = 1'b1;
        if (opcode_s == OP_STA) begin
          state_d = ST_EXM_WR;
        end else begin
          state_d = ST_EXM_RD;
        end
      end
      ST_EXM_RD: begin
        ctrl_s.mem_rd = 1'b1;
        if (cs.mem_ready) begin
          ctrl_s.rega_load = 1'b1;
          state_d          = ST_FETCH1;
        end else if (expired_s) begin
          state_d = ST_FAULT;
        end else begin
          tick_s = 1'b1;
        end
      end
      ST_EXM_WR: begin
        ctrl_s.rega_out = 1'b1;
        ctrl_s.mem_wr   = 1'b1;
        if (cs.mem_ready) begin
          state_d = ST_FETCH1;
        end else if (expired_s) begin
          state_d = ST_FAULT;
        end else begin
          tick_s = 1'b1;
        end
      end
      ST_EXALU: begin
        ctrl_s.alu_out   = 1'b1;
        ctrl_s.rega_load = 1'b1;
        alu_s            = alu_sel(opcode_s);
        state_d          = ST_FETCH1;
      end
      ST_JUMP: begin
        ctrl_s.ir_out  = 1'b1;
        ctrl_s.pc_load = 1'b1;
        state_d        = ST_FETCH1;
      end
      ST_HALT: begin
        ctrl_s.halted = 1'b1;
        state_d       = ST_HALT;
      end
      ST_FAULT: begin
        ctrl_s.fault = 1'b1;
        state_d      = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Timer clears only on the transition into a wait state.
  always_comb begin
    if (is_wait_state(state_d) && (state_d != state_q)) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
  end

  // While reset is held, state shows FETCH1 but no FETCH1 controls may leak out.
  always_comb begin
    if (r) begin
      ctrl_out_s = ctrl_s;
      alu_out_s  = alu_s;
    end else begin
      ctrl_out_s = '0;
      alu_out_s  = ALU_NONE;
    end
  end

  assign cs.pc_out     = ctrl_out_s.pc_out;
  assign cs.pc_inc     = ctrl_out_s.pc_inc;
  assign cs.pc_load    = ctrl_out_s.pc_load;
  assign cs.mar_load   = ctrl_out_s.mar_load;
  assign cs.ir_load    = ctrl_out_s.ir_load;
  assign cs.ir_out     = ctrl_out_s.ir_out;
  assign cs.mem_rd     = ctrl_out_s.mem_rd;
  assign cs.mem_wr     = ctrl_out_s.mem_wr;
  assign cs.rega_load  = ctrl_out_s.rega_load;
  assign cs.rega_out   = ctrl_out_s.rega_out;
  assign cs.alu_out    = ctrl_out_s.alu_out;
  assign cs.halted     = ctrl_out_s.halted;
  assign cs.fault      = ctrl_out_s.fault;
  assign cs.alu_op     = alu_out_s;
  assign cs.ir_operand = {4'h0, ir_q[11:0]};
  assign cs.state      = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle stimulus and expected
// control vectors are queued by each scenario, then replayed and compared.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic r   = 1'b1;

  always #5 clk = ~clk;

  control_sequencer_if ifc ();

  control_sequencer #(
    .WAIT_MAX(4)
  ) dut (
    .clk(clk),
    .r  (r),
    .cs (ifc.master)
  );

  typedef struct packed {
    logic        rr;
    logic        rdy;
    logic        z;
    logic [15:0] bus;
  } stim_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [12:0] ctrl;
    logic [2:0]  alu;
    logic [15:0] opnd;
  } obs_t;

  localparam logic [12:0] C_NONE    = 13'h0000;
  localparam logic [12:0] C_PC_OUT  = 13'h1000;
  localparam logic [12:0] C_PC_INC  = 13'h0800;
  localparam logic [12:0] C_PC_LOAD = 13'h0400;
  localparam logic [12:0] C_MAR     = 13'h0200;
  localparam logic [12:0] C_IR_LOAD = 13'h0100;
  localparam logic [12:0] C_IR_OUT  = 13'h0080;
  localparam logic [12:0] C_MEM_RD  = 13'h0040;
  localparam logic [12:0] C_MEM_WR  = 13'h0020;
  localparam logic [12:0] C_RA_LOAD = 13'h0010;
  localparam logic [12:0] C_RA_OUT  = 13'h0008;
  localparam logic [12:0] C_ALU_OUT = 13'h0004;
  localparam logic [12:0] C_HALT    = 13'h0002;
  localparam logic [12:0] C_FAULT   = 13'h0001;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc;
  obs_t  got;
  obs_t  want;

  task automatic push(input logic rr, input logic rdy, input logic z, input logic [15:0] bus,
                      input state_t st, input logic [12:0] c, input logic [2:0] alu,
                      input logic [15:0] opnd);
    stim_q.push_back({rr, rdy, z, bus});
    exp_q.push_back({st, c, alu, opnd});
  endtask

  task automatic push_reset();
    push(1'b0, 1'b1, 1'b0, 16'hFFFF, ST_FETCH1, C_NONE, 3'b000, 16'h0000);
  endtask

  // FETCH1 + zero-wait FETCH2 of word; prev is the operand visible before the load.
  task automatic push_fetch(input logic [15:0] word, input logic [15:0] prev);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, prev);
    push(1'b1, 1'b1, 1'b0, word, ST_FETCH2, C_MEM_RD | C_IR_LOAD | C_PC_INC, 3'b000, prev);
  endtask

  task automatic drive_cycle(input stim_t s, output obs_t o);
    @(negedge clk);
    r             = s.rr;
    ifc.mem_ready = s.rdy;
    ifc.zero      = s.z;
    ifc.bus_in    = s.bus;
    #1;
    o = {ifc.state,
         ifc.pc_out, ifc.pc_inc, ifc.pc_load, ifc.mar_load, ifc.ir_load, ifc.ir_out,
         ifc.mem_rd, ifc.mem_wr, ifc.rega_load, ifc.rega_out, ifc.alu_out, ifc.halted,
         ifc.fault, ifc.alu_op, ifc.ir_operand};
  endtask

  task automatic test_reset();
    push_reset();
    push_reset();
    push_reset();
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h want %h", cyc, got, want);
      end
      cyc++;
    end
  endtask

  task automatic test_nop_loop();
    push_reset();
    for (int i = 0; i < 3; i++) begin
      push_fetch(16'h0000, 16'h0000);
      push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0000);
    end
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0000);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL nop_loop cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl nop_loop cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  task automatic test_lda();
    push_reset();
    push_fetch(16'h1123, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0123);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_EXA, C_IR_OUT | C_MAR, 3'b000, 16'h0123);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_EXM_RD, C_MEM_RD | C_RA_LOAD, 3'b000, 16'h0123);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0123);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL lda cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl lda cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  task automatic test_alu();
    logic [2:0]  alu_tbl [4];
    logic [15:0] word;
    logic [15:0] prev;
    alu_tbl = '{3'b000, 3'b001, 3'b010, 3'b011};
    prev = 16'h0000;
    push_reset();
    for (int i = 0; i < 4; i++) begin
      word = {4'(3 + i), 12'h0A0 + 12'(i)};
      push_fetch(word, prev);
      prev = {4'h0, word[11:0]};
      push(1'b1, 1'b0, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, prev);
      push(1'b1, 1'b1, 1'b1, 16'h0000, ST_EXALU, C_ALU_OUT | C_RA_LOAD, alu_tbl[i], prev);
    end
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, prev);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL alu cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl alu cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  task automatic test_jump();
    push_reset();
    push_fetch(16'h8040, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0040);
    push_fetch(16'h8040, 16'h0040);
    push(1'b1, 1'b1, 1'b1, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0040);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_JUMP, C_IR_OUT | C_PC_LOAD, 3'b000, 16'h0040);
    push_fetch(16'h7ABC, 16'h0040);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0ABC);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_JUMP, C_IR_OUT | C_PC_LOAD, 3'b000, 16'h0ABC);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0ABC);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL jump cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl jump cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  // Ready arriving on the WAIT_MAX-th wait cycle must still complete the access.
  task automatic test_wait_states();
    push_reset();
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 1'b0, 16'h3FFF, ST_FETCH2, C_MEM_RD, 3'b000, 16'h0000);
    end
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH2, C_MEM_RD | C_IR_LOAD | C_PC_INC, 3'b000, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0000);
    push_fetch(16'h1ABC, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0ABC);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXA, C_IR_OUT | C_MAR, 3'b000, 16'h0ABC);
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXM_RD, C_MEM_RD, 3'b000, 16'h0ABC);
    end
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_EXM_RD, C_MEM_RD | C_RA_LOAD, 3'b000, 16'h0ABC);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0ABC);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wait_states cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl wait_states cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  task automatic test_timeout();
    push_reset();
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 1'b0, 1'b0, 16'hF000, ST_FETCH2, C_MEM_RD, 3'b000, 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b1, 1'b1, 16'h0000, ST_FAULT, C_FAULT, 3'b000, 16'h0000);
    end
    push_reset();
    push_fetch(16'h2010, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0010);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXA, C_IR_OUT | C_MAR, 3'b000, 16'h0010);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXM_WR, C_RA_OUT | C_MEM_WR, 3'b000, 16'h0010);
    end
    for (int i = 0; i < 2; i++) begin
      push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FAULT, C_FAULT, 3'b000, 16'h0010);
    end
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timeout cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl timeout cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  task automatic test_halt_illegal();
    push_reset();
    push_fetch(16'hF000, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 1'b1, 1'b1, 16'h0000, ST_HALT, C_HALT, 3'b000, 16'h0000);
    end
    push_reset();
    push_fetch(16'h9000, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FAULT, C_FAULT, 3'b000, 16'h0000);
    push_reset();
    push_fetch(16'hE123, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0123);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_FAULT, C_FAULT, 3'b000, 16'h0123);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL halt_illegal cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl halt_illegal cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  // A completed store, then a second store abandoned by reset mid-handshake.
  task automatic test_reset_mid_write();
    push_reset();
    push_fetch(16'h2055, 16'h0000);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0055);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXA, C_IR_OUT | C_MAR, 3'b000, 16'h0055);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXM_WR, C_RA_OUT | C_MEM_WR, 3'b000, 16'h0055);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_EXM_WR, C_RA_OUT | C_MEM_WR, 3'b000, 16'h0055);
    push_fetch(16'h2077, 16'h0055);
    push(1'b1, 1'b1, 1'b0, 16'h0000, ST_DECODE, C_NONE, 3'b000, 16'h0077);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXA, C_IR_OUT | C_MAR, 3'b000, 16'h0077);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXM_WR, C_RA_OUT | C_MEM_WR, 3'b000, 16'h0077);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_EXM_WR, C_RA_OUT | C_MEM_WR, 3'b000, 16'h0077);
    push_reset();
    push_reset();
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_FETCH1, C_PC_OUT | C_MAR, 3'b000, 16'h0000);
    push(1'b1, 1'b0, 1'b0, 16'h0000, ST_FETCH2, C_MEM_RD, 3'b000, 16'h0000);
    cyc = 0;
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front(), got);
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_write cyc %0d: got %h want %h", cyc, got, want);
      end
      checks++;
      if ($countones({got.ctrl[12], got.ctrl[7], got.ctrl[3], got.ctrl[2]}) > 1) begin
        errors++;
        $display("FAIL bus_excl reset_mid_write cyc %0d: ctrl %b", cyc, got.ctrl);
      end
      cyc++;
    end
  endtask

  initial begin
    ifc.bus_in    = 16'h0000;
    ifc.mem_ready = 1'b0;
    ifc.zero      = 1'b0;
    #1;
    r = 1'b0;
    test_reset();
    test_nop_loop();
    test_lda();
    test_alu();
    test_jump();
    test_wait_states();
    test_timeout();
    test_halt_illegal();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, meaning the maximum number of cycles spent in one memory-wait state before a fault is raised (range 1..255).
REQ-002 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 r  input  1  asynchronous, active-low reset.
REQ-004 bus_in  input  16  shared CPU bus, sampled as the instruction word when ir_load is high.
REQ-005 mem_ready  input  1  memory handshake completion, qualifying mem_rd or mem_wr.
REQ-006 zero  input  1  ALU zero flag (flags bit 0).
REQ-007 Outputs, each 1 bit: pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out, mem_rd, mem_wr, rega_load, rega_out, alu_out, halted, fault.
REQ-008 alu_op  output  3  ALU operation select: ADD=000, SUB=001, AND=010, OR=011; 000 when unused.
REQ-009 ir_operand  output  16  {4'h0, ir[11:0]}, the operand value driven onto the bus whenever ir_out is high.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 Instruction register ir SHALL be 16 bits; opcode = ir[15:12] and operand = ir[11:0].
REQ-012 States: FETCH1, FETCH2, DECODE, EXA, EXM_RD, EXM_WR, EXALU, JUMP, HALT, FAULT.
REQ-013 FETCH1: pc_out and mar_load high for one cycle, then go to FETCH2.
REQ-014 FETCH2: mem_rd high until mem_ready is sampled high; in that cycle ir_load and pc_inc are high, bus_in is loaded into ir, and the next state is DECODE.
REQ-015 DECODE: one cycle, all controls low; the next state is chosen by opcode as follows.
- 0 NOP -> FETCH1.
- 1 LDA, 2 STA -> EXA.
- 3..6 ADD/SUB/AND/OR -> EXALU.
- 7 JMP -> JUMP.
- 8 JZ -> JUMP if zero is high in the DECODE cycle, else FETCH1.
- F HLT -> HALT.
- 9..E -> FAULT.
REQ-016 EXA: ir_out and mar_load high for one cycle; the next state is EXM_RD for LDA and EXM_WR for STA.
REQ-017 EXM_RD: mem_rd high until mem_ready; in the mem_ready cycle rega_load is high; then go to FETCH1.
REQ-018 EXM_WR: rega_out and mem_wr high until mem_ready; then go to FETCH1.
REQ-019 EXALU: alu_out and rega_load high, alu_op = opcode-3, for one cycle; then go to FETCH1.
REQ-020 JUMP: ir_out and pc_load high for one cycle; then go to FETCH1.
REQ-021 HALT: halted=1, all other controls 0; this state is held until reset.
REQ-022 FAULT: fault=1, all other controls 0; this state is held until reset.
REQ-023 Outputs SHALL be a combinational function of the state and ir registers only; mem_ready is used only to gate the wait-state exit and the same-cycle ir_load, pc_inc and rega_load.
REQ-024 At most one of pc_out, ir_out, rega_out and alu_out SHALL be high in any cycle (bus exclusivity).
REQ-025 A mem_ready already high on the first cycle of a wait state SHALL complete that state in one cycle (zero-wait access).
REQ-026 The wait counter SHALL clear on entry to each wait state and increment on each cycle without mem_ready.
REQ-027 When the wait counter reaches WAIT_MAX with mem_ready low, the next state SHALL be FAULT, with no ir_load, pc_inc or rega_load in that cycle.
REQ-028 If mem_ready is high in the cycle the count equals WAIT_MAX, the access SHALL complete normally (ready wins).
REQ-029 mem_ready sampled outside a wait state SHALL be ignored.

Reset
REQ-030 While r=0, the block SHALL immediately (asynchronously) set state=FETCH1, ir=0 and wait counter=0, and drive all outputs to 0 except the state output, which shows FETCH1.
REQ-031 Reset asserted mid-instruction or mid-handshake SHALL abandon the operation with no partial pulse after release.
REQ-032 The first rising clk edge after r returns to 1 SHALL execute FETCH1.

Structure
REQ-033 Package cpu_ctrl_pkg SHALL hold the state enum, the opcode constants and the alu_op encodings.
REQ-034 The wait counter and its timeout compare SHALL be the sub-module wait_timer (ports: clk, r, clear, tick, expired; parameter WAIT_MAX).
REQ-035 The block SHALL be synthesizable with no latches.

Verification
REQ-036 Reset, mem_ready tied high, every fetch returns 16'h0000 -> repeating FETCH1/FETCH2/DECODE cycle; pc_inc pulses once every 3 cycles.
REQ-037 Fetch 16'h1123 (LDA 0x123) -> EXA cycle shows ir_out=1, mar_load=1, ir_operand=16'h0123; the next cycle shows mem_rd=1 and rega_load=1; 5 cycles in total.
REQ-038 Fetch 16'h8040 (JZ) with zero=0 -> no pc_load, back to FETCH1; repeat with zero=1 -> JUMP state with pc_load=1 and ir_operand=16'h0040.
REQ-039 mem_ready delayed 3 cycles in FETCH2 -> mem_rd high for 4 cycles, exactly one ir_load and one pc_inc, both in the 4th cycle.
REQ-040 WAIT_MAX=4 with mem_ready held low -> fault=1 after 4 FETCH2 cycles, all controls 0; fetching 16'hF000 -> halted=1 with no further pc_out.
REQ-041 Assert r low during EXM_WR -> mem_wr and rega_out drop without waiting for a clock edge; after release, FETCH1 with ir=0; bus exclusivity asserted in every test.
